// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency memory port between instruction fetch (I) and load/store (D).
// Define MEM_ARB_ROUND_ROBIN_EN to break ties round-robin instead of fixed D-over-I priority.
module mem_port_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_ack,
  output logic [DW-1:0]   i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic            d_ack,
  output logic [DW-1:0]   d_rdata,
  output logic            err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_ack,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy
);

  localparam int unsigned BW = DW / 8;
  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic            i_ack_d, d_ack_d, err_d, busy_d;
  logic [DW-1:0]   i_rdata_d, d_rdata_d;
  logic            mem_req_d, mem_we_d;
  logic [AW-1:0]   mem_addr_d;
  logic [DW-1:0]   mem_wdata_d;
  logic [BW-1:0]   mem_be_d;
  logic            prefer_d;
  logic            timed_out;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Last-grant flag: 1 = D was granted last, so a tie goes to I.
  logic last_d, last_d_nxt;
  assign prefer_d = ~last_d;
`else
  assign prefer_d = 1'b1;
`endif

  assign timed_out = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    err_d       = 1'b0;
    i_rdata_d   = '0;
    d_rdata_d   = '0;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_be_d    = mem_be;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_d_nxt  = last_d;
`endif
    case (state)
      IDLE: begin
        if (d_req && (!i_req || prefer_d)) begin
          state_d     = BUSY_D;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_be_d    = d_be;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_d_nxt  = 1'b1;
`endif
        end else if (i_req) begin
          state_d     = BUSY_I;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = i_addr;
          mem_wdata_d = '0;
          mem_be_d    = '1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_d_nxt  = 1'b0;
`endif
        end
      end
      BUSY_I, BUSY_D: begin
        // mem_ack wins over a timeout landing in the same cycle.
        if (mem_ack || timed_out) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          err_d     = ~mem_ack;
          if (state == BUSY_D) begin
            d_ack_d   = 1'b1;
            d_rdata_d = mem_ack ? mem_rdata : '0;
          end else begin
            i_ack_d   = 1'b1;
            i_rdata_d = mem_ack ? mem_rdata : '0;
          end
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      err       <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      busy      <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_d    <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      i_ack     <= i_ack_d;
      d_ack     <= d_ack_d;
      err       <= err_d;
      i_rdata   <= i_rdata_d;
      d_rdata   <= d_rdata_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      mem_be    <= mem_be_d;
      busy      <= busy_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_d    <= last_d_nxt;
`endif
    end
  end

endmodule
